// File: rtl/hub_sys_ctl.sv
// hub_sys_ctl: hub-slot rotation, cog enables/start pointers, clock config and lock pool.
// Optional lock ownership tracking is enabled by defining HUB_SYS_LOCK_OWNER_EN.
module hub_sys_ctl #(
  parameter int NCOG = 8,
  parameter int NLOCK = 8,
  parameter int CFGW = 8,
  localparam int IDW = $clog2(NCOG),
  localparam int LKW = $clog2(NLOCK)
) (
  input  logic             clk_cog,
  input  logic             res,
  input  logic             ena_bus,
  output logic [IDW-1:0]   slot,
  input  logic             req_e,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_d,
  output logic             rsp_v,
  output logic [IDW-1:0]   rsp_id,
  output logic [4:0]       rsp_q,
  output logic             rsp_c,
  output logic [NCOG-1:0]  cog_ena,
  output logic [NCOG-1:0]  ptr_w,
  output logic [25:0]      ptr_d,
  output logic [CFGW-1:0]  cfg
);
  logic [IDW-1:0] slot_q, slot_d, rsp_id_q, rsp_id_d, c_new, cid, tgt;
  logic [LKW-1:0] l_new, lid;
  logic [NCOG-1:0] cog_e_q, cog_e_d, cog_ena_q, cog_ena_d, ptr_w_q, ptr_w_d;
  logic [NLOCK-1:0] lock_e_q, lock_e_d, lock_st_q, lock_st_d;
  logic [CFGW-1:0] cfg_q, cfg_d;
  logic [4:0] rq_q, rq_d;
  logic [25:0] sp_q, sp_d;
  logic rsp_v_q, rsp_v_d, rc_q, rc_d, c_all, l_all, go;
`ifdef HUB_SYS_LOCK_OWNER_EN
  logic [IDW-1:0] own_q [NLOCK];
  logic [IDW-1:0] own_d [NLOCK];
`endif

  always_comb begin
    c_new = IDW'(NCOG-1);
    for (int i = NCOG-1; i >= 0; i--) if (!cog_e_q[i]) c_new = IDW'(i);
    l_new = LKW'(NLOCK-1);
    for (int i = NLOCK-1; i >= 0; i--) if (!lock_e_q[i]) l_new = LKW'(i);
    c_all = &cog_e_q;
    l_all = &lock_e_q;
    cid = req_d[IDW-1:0];
    lid = req_d[LKW-1:0];
    tgt = req_d[5] ? c_new : cid;
    go = ena_bus & req_e;
    slot_d = ena_bus ? slot_q + 1'b1 : slot_q;
    cog_e_d = cog_e_q;
    lock_e_d = lock_e_q;
    lock_st_d = lock_st_q;
    cfg_d = cfg_q;
`ifdef HUB_SYS_LOCK_OWNER_EN
    own_d = own_q;
`endif
    rsp_v_d = go;
    rsp_id_d = go ? slot_q : rsp_id_q;
    rq_d = rq_q;
    rc_d = rc_q;
    ptr_w_d = '0;
    sp_d = sp_q;
    if (go) begin
      case (req_op)
        3'b000: begin cfg_d = req_d[CFGW-1:0]; rq_d = '0; rc_d = 1'b0; end
        3'b001: begin rq_d = 5'(slot_q); rc_d = 1'b0; end
        3'b010: begin
          if (req_d[5] && c_all) begin
            rq_d = 5'(c_new);
            rc_d = 1'b1;
          end else begin
            cog_e_d[tgt] = 1'b1;
            ptr_w_d = NCOG'(1) << tgt;
            sp_d = req_d[31:6];
            rq_d = 5'(tgt);
            rc_d = c_all;
          end
        end
        3'b011: begin
          cog_e_d[cid] = 1'b0;
          rq_d = 5'(cid);
          rc_d = 1'b0;
`ifdef HUB_SYS_LOCK_OWNER_EN
          for (int i = 0; i < NLOCK; i++)
            if (lock_e_q[i] && own_q[i] == cid) begin
              lock_e_d[i] = 1'b0;
              lock_st_d[i] = 1'b0;
            end
`endif
        end
        3'b100: begin
          if (!l_all) lock_e_d[l_new] = 1'b1;
`ifdef HUB_SYS_LOCK_OWNER_EN
          if (!l_all) own_d[l_new] = slot_q;
`endif
          rq_d = 5'(l_new);
          rc_d = l_all;
        end
        3'b101: begin
          rq_d = 5'(lid);
          rc_d = l_all;
`ifdef HUB_SYS_LOCK_OWNER_EN
          // a foreign return is refused and flagged through carry
          if (lock_e_q[lid] && own_q[lid] != slot_q) rc_d = 1'b1;
          else lock_e_d[lid] = 1'b0;
`else
          lock_e_d[lid] = 1'b0;
`endif
        end
        3'b110, 3'b111: begin
          rc_d = lock_st_q[lid];
          lock_st_d[lid] = ~req_op[0];
          rq_d = 5'(lid);
        end
      endcase
    end
    // a (re)started cog is held off for one slot period by its pointer strobe
    cog_ena_d = ena_bus ? cog_e_d & ~ptr_w_d : cog_ena_q;
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      slot_q <= '0;
      cog_e_q <= NCOG'(1);
      cog_ena_q <= '0;
      lock_e_q <= '0;
      lock_st_q <= '0;
      cfg_q <= '0;
      rsp_v_q <= 1'b0;
      rsp_id_q <= '0;
      rq_q <= '0;
      rc_q <= 1'b0;
      ptr_w_q <= '0;
      sp_q <= '0;
`ifdef HUB_SYS_LOCK_OWNER_EN
      for (int i = 0; i < NLOCK; i++) own_q[i] <= '0;
`endif
    end else begin
      slot_q <= slot_d;
      cog_e_q <= cog_e_d;
      cog_ena_q <= cog_ena_d;
      lock_e_q <= lock_e_d;
      lock_st_q <= lock_st_d;
      cfg_q <= cfg_d;
      rsp_v_q <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
      rq_q <= rq_d;
      rc_q <= rc_d;
      ptr_w_q <= ptr_w_d;
      sp_q <= sp_d;
`ifdef HUB_SYS_LOCK_OWNER_EN
      own_q <= own_d;
`endif
    end
  end

  assign slot = slot_q;
  assign rsp_v = rsp_v_q;
  assign rsp_id = rsp_id_q;
  assign rsp_q = rq_q;
  assign rsp_c = rc_q;
  assign cog_ena = cog_ena_q;
  assign ptr_w = ptr_w_q;
  assign ptr_d = sp_q;
  assign cfg = cfg_q;
endmodule

// File: tb/tb_hub_sys_ctl.sv
// tb_hub_sys_ctl: table-driven vectors with a response scoreboard for hub_sys_ctl (NCOG=NLOCK=8).
module tb_hub_sys_ctl;
  localparam logic [2:0] CLK = 3'd0, CID = 3'd1, CIN = 3'd2, CST = 3'd3;
  localparam logic [2:0] LNEW = 3'd4, LRET = 3'd5, LSET = 3'd6, LCLR = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [31:0] d;
    logic [4:0] q;
    logic c;
    logic [7:0] pw;
    logic sq;
  } vec_t;

  typedef struct {
    logic [2:0] id;
    logic [4:0] q;
    logic c;
    logic [7:0] pw;
    logic [25:0] pd;
  } exp_t;

  logic clk = 1'b0, res, ena_bus, req_e;
  logic [2:0] req_op, slot, rsp_id, mslot;
  logic [31:0] req_d;
  logic rsp_v, rsp_c;
  logic [4:0] rsp_q;
  logic [7:0] cog_ena, ptr_w, cfg;
  logic [25:0] ptr_d;
  exp_t sb[$];
  vec_t tv[$];
  int n_chk = 0, n_fail = 0;

  hub_sys_ctl dut (
    .clk_cog(clk), .res(res), .ena_bus(ena_bus), .slot(slot), .req_e(req_e),
    .req_op(req_op), .req_d(req_d), .rsp_v(rsp_v), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_c(rsp_c), .cog_ena(cog_ena), .ptr_w(ptr_w), .ptr_d(ptr_d), .cfg(cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic vec_t v(logic [2:0] op, logic [31:0] d, logic [4:0] q, logic c,
                             logic [7:0] pw, logic sq);
    vec_t r;
    r.op = op; r.d = d; r.q = q; r.c = c; r.pw = pw; r.sq = sq;
    return r;
  endfunction

  function automatic logic [31:0] ci(logic nx, logic [4:0] id, logic [25:0] p);
    return {p, nx, id};
  endfunction

  task automatic tick(input logic e, input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    ena_bus = 1'b1; req_e = e; req_op = op; req_d = d;
    @(posedge clk);
    mslot++;
    #1 ena_bus = 1'b0; req_e = 1'b0;
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] d, input logic [4:0] q,
                     input logic c, input logic [7:0] pw, input logic sq);
    exp_t e;
    e.id = mslot; e.q = sq ? 5'(mslot) : q; e.c = c; e.pw = pw; e.pd = d[31:6];
    sb.push_back(e);
    tick(1'b1, op, d);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 3'd0, 32'd0);
  endtask

  task automatic do_reset();
    res = 1'b1; ena_bus = 1'b0; req_e = 1'b0;
    sb.delete();
    mslot = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_slot"}, 32'(slot), 0);
    chk({n, "_cog_ena"}, 32'(cog_ena), 0);
    chk({n, "_rsp_v"}, 32'(rsp_v), 0);
    chk({n, "_rsp_id"}, 32'(rsp_id), 0);
    chk({n, "_rsp_q"}, 32'(rsp_q), 0);
    chk({n, "_rsp_c"}, 32'(rsp_c), 0);
    chk({n, "_ptr_w"}, 32'(ptr_w), 0);
    chk({n, "_ptr_d"}, 32'(ptr_d), 0);
    chk({n, "_cfg"}, 32'(cfg), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!res && rsp_v) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_v), 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_q", 32'(rsp_q), 32'(e.q));
        chk("rsp_c", 32'(rsp_c), 32'(e.c));
        chk("ptr_w", 32'(ptr_w), 32'(e.pw));
        if (e.pw != 0) chk("ptr_d", 32'(ptr_d), 32'(e.pd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_op = '0; req_d = '0;
    tv.push_back(v(CLK, 32'hA5, 0, 0, 8'h00, 0));
    tv.push_back(v(CID, 32'h0, 0, 0, 8'h00, 1));
    for (int i = 0; i < 8; i++) tv.push_back(v(LNEW, 32'h0, 5'(i), 0, 8'h00, 0));
    tv.push_back(v(LNEW, 32'h0, 7, 1, 8'h00, 0));
    tv.push_back(v(LSET, 32'h5, 5, 0, 8'h00, 0));
    tv.push_back(v(LSET, 32'h5, 5, 1, 8'h00, 0));
    tv.push_back(v(LCLR, 32'h5, 5, 1, 8'h00, 0));
    tv.push_back(v(LCLR, 32'h5, 5, 0, 8'h00, 0));
    tv.push_back(v(LSET, 32'h1D, 5, 0, 8'h00, 0));
    tv.push_back(v(LSET, 32'h1D, 5, 1, 8'h00, 0));
    tv.push_back(v(LSET, 32'h2, 2, 0, 8'h00, 0));
    tv.push_back(v(LCLR, 32'h2, 2, 1, 8'h00, 0));
    tv.push_back(v(CIN, ci(0, 6, 26'h2AA), 6, 0, 8'h40, 0));
    tv.push_back(v(CIN, ci(1, 0, 26'h3), 2, 0, 8'h04, 0));
    tv.push_back(v(CST, 32'h1, 1, 0, 8'h00, 0));
    tv.push_back(v(CIN, ci(1, 0, 26'h7), 1, 0, 8'h02, 0));
    tv.push_back(v(CIN, ci(0, 9, 26'h5), 1, 0, 8'h02, 0));
    tv.push_back(v(CIN, ci(0, 3, 26'h8), 3, 0, 8'h08, 0));
    tv.push_back(v(CIN, ci(1, 0, 26'h9), 4, 0, 8'h10, 0));
    tv.push_back(v(CIN, ci(1, 0, 26'hA), 5, 0, 8'h20, 0));
    tv.push_back(v(CIN, ci(1, 0, 26'hB), 7, 0, 8'h80, 0));
    tv.push_back(v(CIN, ci(1, 0, 26'hC), 7, 1, 8'h00, 0));
    tv.push_back(v(CIN, ci(0, 2, 26'h1FF), 2, 1, 8'h04, 0));
    tv.push_back(v(CST, 32'h7, 7, 0, 8'h00, 0));
    tv.push_back(v(CID, 32'h0, 0, 0, 8'h00, 1));
    tv.push_back(v(CLK, 32'h3C, 0, 0, 8'h00, 0));

    do_reset();
    chk_reset_vals("reset");

    for (int i = 0; i < 8; i++) begin
      chk("slot_walk", 32'(slot), 32'(i));
      idle(1);
      if (i == 0) chk("cog_ena_first", 32'(cog_ena), 32'h01);
      chk("no_rsp_v", 32'(rsp_v), 0);
    end
    chk("slot_wrap", 32'(slot), 0);

    idle(3);
    chk("slot3", 32'(slot), 3);
    req(CIN, ci(1, 0, 26'h123), 1, 0, 8'h02, 0);
    chk("start_ena_low", 32'(cog_ena), 32'h01);
    chk("start_ptr_w", 32'(ptr_w), 32'h02);
    idle(1);
    chk("start_ena_high", 32'(cog_ena), 32'h03);
    chk("ptr_w_drop", 32'(ptr_w), 0);
    chk("rsp_v_drop", 32'(rsp_v), 0);
    chk("ptr_d_hold", 32'(ptr_d), 32'h123);
    chk("rsp_q_hold", 32'(rsp_q), 1);

    foreach (tv[i]) req(tv[i].op, tv[i].d, tv[i].q, tv[i].c, tv[i].pw, tv[i].sq);
    idle(1);
    chk("cfg_final", 32'(cfg), 32'h3C);
    chk("cog_ena_final", 32'(cog_ena), 32'h7F);
    chk("ptr_d_final", 32'(ptr_d), 32'h1FF);
    chk("rsp_q_final", 32'(rsp_q), 0);

    do_reset();
    req(LNEW, 32'h0, 0, 0, 8'h00, 0);
    idle(7);
    req(LRET, 32'h0, 0, 0, 8'h00, 0);
    req(LNEW, 32'h0, 0, 0, 8'h00, 0);

    do_reset();
    idle(2);
    req(LNEW, 32'h0, 0, 0, 8'h00, 0);
    req(LSET, 32'h0, 0, 0, 8'h00, 0);
`ifdef HUB_SYS_LOCK_OWNER_EN
    req(LRET, 32'h0, 0, 1, 8'h00, 0);
    req(LNEW, 32'h0, 1, 0, 8'h00, 0);
    req(CST, 32'h2, 2, 0, 8'h00, 0);
    req(LNEW, 32'h0, 0, 0, 8'h00, 0);
    req(LSET, 32'h0, 0, 0, 8'h00, 0);
`else
    req(LRET, 32'h0, 0, 0, 8'h00, 0);
    req(LNEW, 32'h0, 0, 0, 8'h00, 0);
    req(CST, 32'h2, 2, 0, 8'h00, 0);
    req(LNEW, 32'h0, 1, 0, 8'h00, 0);
    req(LSET, 32'h0, 0, 1, 8'h00, 0);
`endif

    req(CLK, 32'h77, 0, 0, 8'h00, 0);
    req(CIN, ci(1, 0, 26'h155), 1, 0, 8'h02, 0);
    chk("pre_reset_rsp_v", 32'(rsp_v), 1);
    chk("pre_reset_ptr_w", 32'(ptr_w), 32'h02);
    res = 1'b1;
    sb.delete();
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    res = 1'b0;
    mslot = '0;
    idle(1);
    chk("post_reset_cog_ena", 32'(cog_ena), 32'h01);
    chk("post_reset_slot", 32'(slot), 1);
    chk("post_reset_rsp_v", 32'(rsp_v), 0);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
